// File: rtl/multi_port_csr_router_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multi_port_csr_router_pkg
// Brief   : Shared types and helpers for the multi-port CSR router.
// Revision: 1.0 - initial release
// ============================================================================
package multi_port_csr_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } t_mpcr_state;

  localparam logic [31:0] MPCR_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // The all-ones select value of a sel_w-bit field addresses every port.
  function automatic logic is_bcast(input logic [7:0] sel, input int unsigned sel_w);
    logic [7:0] mask;
    mask = 8'((9'd1 << sel_w) - 9'd1);
    return ((sel & mask) == mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_port_csr_router.sv
`default_nettype none
// ============================================================================
// Module  : multi_port_csr_router
// Brief   : Sequenced Avalon-MM CSR router from one master to NUM_PORTS slaves,
//           with broadcast writes, bad-port protection and sticky errors.
//           Optional slave timeout: define MULTI_PORT_CSR_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module multi_port_csr_router
  import multi_port_csr_router_pkg::*;
#(
  parameter int unsigned              NUM_PORTS      = 8,
  parameter int unsigned              AVMM_DATA_W    = 32,
  parameter int unsigned              AVMM_ADDR_W    = 16,
  parameter int unsigned              SEL_W          = 4,
  parameter int unsigned              TIMEOUT_CYCLES = 1024,
  parameter logic [AVMM_DATA_W-1:0]   TIMEOUT_DATA   = AVMM_DATA_W'(MPCR_TIMEOUT_DATA)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [AVMM_ADDR_W-1:0]           i_avmm_addr,
  input  logic                             i_avmm_read,
  input  logic                             i_avmm_write,
  input  logic [AVMM_DATA_W-1:0]           i_avmm_writedata,
  output logic [AVMM_DATA_W-1:0]           o_avmm_readdata,
  output logic                             o_avmm_waitrequest,
  input  logic [SEL_W-1:0]                 i_csr_port_sel,
  output logic [NUM_PORTS-1:0]             o_port_read,
  output logic [NUM_PORTS-1:0]             o_port_write,
  output logic [AVMM_ADDR_W-1:0]           o_port_addr,
  output logic [AVMM_DATA_W-1:0]           o_port_writedata,
  input  logic [NUM_PORTS*AVMM_DATA_W-1:0] i_port_readdata,
  input  logic [NUM_PORTS-1:0]             i_port_waitrequest,
  input  logic                             i_err_clear,
  output logic                             o_err_bad_port,
  output logic                             o_err_timeout,
  output logic                             o_busy
);

  localparam logic [SEL_W:0]   C_NP_EXT    = (SEL_W+1)'(NUM_PORTS);
  localparam logic [SEL_W-1:0] C_LAST_PORT = SEL_W'(NUM_PORTS-1);

  t_mpcr_state            state_q, state_d;
  logic [AVMM_ADDR_W-1:0] addr_q, addr_d;
  logic [AVMM_DATA_W-1:0] wdata_q, wdata_d;
  logic [AVMM_DATA_W-1:0] rdata_q, rdata_d;
  logic                   wr_q, wr_d;
  logic                   bcast_q, bcast_d;
  logic [SEL_W-1:0]       cur_q, cur_d;
  logic                   err_bad_q, err_bad_d;

  logic [NUM_PORTS-1:0]   w_cur_onehot;
  logic [AVMM_DATA_W-1:0] w_port_rdata;
  logic                   w_port_wait;
  logic                   w_sel_bcast;
  logic                   w_set_bad;
  logic                   w_to_hit;

  always_comb begin
    w_cur_onehot = '0;
    w_port_rdata = '0;
    w_port_wait  = 1'b1;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (cur_q == SEL_W'(p)) begin
        w_cur_onehot[p] = 1'b1;
        w_port_rdata    = i_port_readdata[p*AVMM_DATA_W +: AVMM_DATA_W];
        w_port_wait     = i_port_waitrequest[p];
      end
    end
  end

  assign w_sel_bcast = is_bcast(8'(i_csr_port_sel), SEL_W);

`ifdef MULTI_PORT_CSR_TIMEOUT_EN
  localparam int unsigned          C_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0]   C_TO_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [C_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic               err_to_q, err_to_d;

  assign w_to_hit = (state_q == ISSUE) && w_port_wait && (to_cnt_q == C_TO_LAST);

  // Counts stalled cycles of the current port only; any acceptance restarts it.
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == ISSUE) && w_port_wait && !w_to_hit) to_cnt_d = to_cnt_q + 1'b1;
    err_to_d = w_to_hit ? 1'b1 : (i_err_clear ? 1'b0 : err_to_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign o_err_timeout = err_to_q;
`else
  assign w_to_hit      = 1'b0;
  assign o_err_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    bcast_d   = bcast_q;
    cur_d     = cur_q;
    w_set_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_avmm_read || i_avmm_write) begin
          addr_d  = i_avmm_addr;
          wdata_d = i_avmm_writedata;
          wr_d    = i_avmm_write;
          bcast_d = 1'b0;
          cur_d   = i_csr_port_sel;
          if (w_sel_bcast && i_avmm_write) begin
            bcast_d = 1'b1;
            cur_d   = '0;
            state_d = ISSUE;
          end else if ({1'b0, i_csr_port_sel} < C_NP_EXT) begin
            state_d = ISSUE;
          end else begin
            w_set_bad = 1'b1;
            rdata_d   = TIMEOUT_DATA;
            state_d   = RESP;
          end
        end
      end
      ISSUE: begin
        if (w_to_hit) begin
          rdata_d = TIMEOUT_DATA;
          state_d = RESP;
        end else if (!w_port_wait) begin
          rdata_d = w_port_rdata;
          if (bcast_q && (cur_q != C_LAST_PORT)) cur_d = cur_q + 1'b1;
          else                                    state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_bad_d = w_set_bad ? 1'b1 : (i_err_clear ? 1'b0 : err_bad_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      bcast_q   <= 1'b0;
      cur_q     <= '0;
      err_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wr_q      <= wr_d;
      bcast_q   <= bcast_d;
      cur_q     <= cur_d;
      err_bad_q <= err_bad_d;
    end
  end

  // Strobes decode from the async-reset state so they fall the instant reset rises.
  assign o_port_read        = ((state_q == ISSUE) && !wr_q) ? w_cur_onehot : '0;
  assign o_port_write       = ((state_q == ISSUE) &&  wr_q) ? w_cur_onehot : '0;
  assign o_port_addr        = addr_q;
  assign o_port_writedata   = wdata_q;
  assign o_avmm_readdata    = rdata_q;
  assign o_avmm_waitrequest = (state_q != RESP);
  assign o_err_bad_port     = err_bad_q;
  assign o_busy             = (state_q != IDLE);

endmodule
`default_nettype wire
